// File: rtl/dcp_pkg.sv
// Shared types and constants for the memory-dump command processor.
// DCP_DUMP_CSUM_EN adds the per-line XOR checksum states.
package dcp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SCAN,
        ST_PFX,
        ST_ADDR,
        ST_COLON,
        ST_RD,
        ST_WORD,
        ST_SEP,
`ifdef DCP_DUMP_CSUM_EN
        ST_CSUM_MARK,
        ST_CSUM,
`endif
        ST_CR,
        ST_LF,
        ST_DONE
    } dcp_state_e;

    localparam logic [7:0] CHR_DASH  = 8'h2D;
    localparam logic [7:0] CHR_COLON = 8'h3A;
    localparam logic [7:0] CHR_SP    = 8'h20;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_HASH  = 8'h23;

    localparam logic TX_CHAR = 1'b0;
    localparam logic TX_HEX  = 1'b1;

    function automatic logic [31:0] chr32(input logic [7:0] c);
        return {24'h0, c};
    endfunction

endpackage

// File: rtl/dcp_tx_port.sv
// Transmitter request/acknowledge handshake; the sequencer only raises start
// while it wants an item sent and advances on the one-cycle done.
module dcp_tx_port (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] payload,
    input  logic        ptype,
    input  logic        ack_tx,
    output logic        req_tx,
    output logic        done,
    output logic [31:0] dout,
    output logic        type_tx
);

    // Clearing on acknowledge has priority over start, guaranteeing an idle
    // cycle between consecutive items.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            req_tx <= 1'b0;
        end else if (req_tx && ack_tx) begin
            req_tx <= 1'b0;
        end else if (start) begin
            req_tx <= 1'b1;
        end
    end

    assign done    = req_tx & ack_tx;
    assign dout    = payload;
    assign type_tx = ptype;

endmodule

// File: rtl/dcp_dump.sv
// Memory-dump command processor: reads a start address, streams formatted hex
// lines through the transmitter. DCP_DUMP_CSUM_EN appends a per-line XOR checksum.
//
// state     | meaning
// IDLE      | waiting for sel_mode == CMD_CODE
// SCAN      | receiver handshake for start address (or resume)
// PFX       | emit CMD_CODE then '-'
// ADDR      | emit current address as hex
// COLON     | emit ':'
// RD        | wait out memory latency, capture word
// WORD      | emit captured word as hex, advance address
// SEP       | emit ' ' between words
// CSUM_MARK | emit '#'
// CSUM      | emit line checksum as hex
// CR / LF   | end of line
// DONE      | finish held until sel_mode drops
module dcp_dump
    import dcp_pkg::*;
#(
    parameter logic [7:0] CMD_CODE       = 8'h49,
    parameter int         ADDR_W         = 32,
    parameter int         DATA_W         = 32,
    parameter int         WORDS_PER_LINE = 4,
    parameter int         LINES          = 2,
    parameter int         ADDR_STEP      = 1,
    parameter int         MEM_LAT        = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        sel_mode,
    output logic              finish,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dout_mem,
    input  logic [31:0]       din_rx,
    input  logic              flag_rx,
    input  logic              ack_rx,
    output logic              req_rx,
    output logic              type_rx,
    input  logic              ack_tx,
    output logic              req_tx,
    output logic              type_tx,
    output logic [31:0]       dout
);

    localparam logic [3:0]        WPL_LAST  = 4'(WORDS_PER_LINE - 1);
    localparam logic [7:0]        LINE_LAST = 8'(LINES - 1);
    localparam int                LAT_M1    = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;
    localparam logic [1:0]        LAT_INIT  = 2'(LAT_M1);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

    dcp_state_e        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] data_reg;
    logic [7:0]        line_cnt;
    logic [3:0]        word_cnt;
    logic [1:0]        lat_cnt;
    logic              pfx_idx;
    logic              we;
    logic              capture;
    logic              tx_start;
    logic              tx_done;
    logic              tx_type;
    logic [31:0]       tx_payload;
`ifdef DCP_DUMP_CSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    assign we      = (sel_mode == CMD_CODE);
    assign addr    = cur_addr;
    assign type_rx = 1'b1;

    // Zero latency folds the capture into the edge that leaves COLON/SEP.
    always_comb begin
        if (MEM_LAT == 0) begin
            capture = (state == ST_COLON || state == ST_SEP) && tx_done;
        end else begin
            capture = (state == ST_RD) && (lat_cnt == 2'd0);
        end
    end

    always_comb begin
        tx_start   = 1'b0;
        tx_type    = TX_CHAR;
        tx_payload = chr32(CHR_SP);
        case (state)
            ST_PFX: begin
                tx_start   = 1'b1;
                tx_payload = pfx_idx ? chr32(CHR_DASH) : chr32(CMD_CODE);
            end
            ST_ADDR: begin
                tx_start   = 1'b1;
                tx_type    = TX_HEX;
                tx_payload = 32'(cur_addr);
            end
            ST_COLON: begin
                tx_start   = 1'b1;
                tx_payload = chr32(CHR_COLON);
            end
            ST_WORD: begin
                tx_start   = 1'b1;
                tx_type    = TX_HEX;
                tx_payload = 32'(data_reg);
            end
            ST_SEP: begin
                tx_start   = 1'b1;
                tx_payload = chr32(CHR_SP);
            end
`ifdef DCP_DUMP_CSUM_EN
            ST_CSUM_MARK: begin
                tx_start   = 1'b1;
                tx_payload = chr32(CHR_HASH);
            end
            ST_CSUM: begin
                tx_start   = 1'b1;
                tx_type    = TX_HEX;
                tx_payload = 32'(csum);
            end
`endif
            ST_CR: begin
                tx_start   = 1'b1;
                tx_payload = chr32(CHR_CR);
            end
            ST_LF: begin
                tx_start   = 1'b1;
                tx_payload = chr32(CHR_LF);
            end
            default: ;
        endcase
    end

    dcp_tx_port u_tx (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (!we),
        .start   (tx_start),
        .payload (tx_payload),
        .ptype   (tx_type),
        .ack_tx  (ack_tx),
        .req_tx  (req_tx),
        .done    (tx_done),
        .dout    (dout),
        .type_tx (type_tx)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            last_addr <= '0;
            data_reg  <= '0;
            line_cnt  <= '0;
            word_cnt  <= '0;
            lat_cnt   <= '0;
            pfx_idx   <= 1'b0;
            finish    <= 1'b0;
            req_rx    <= 1'b0;
`ifdef DCP_DUMP_CSUM_EN
            csum      <= '0;
`endif
        end else if (!we) begin
            // Abort leaves last_addr untouched so a partial dump is not resumable.
            state  <= ST_IDLE;
            req_rx <= 1'b0;
            finish <= 1'b0;
        end else begin
            if (capture) begin
                data_reg <= dout_mem;
            end
`ifdef DCP_DUMP_CSUM_EN
            if (state == ST_ADDR) begin
                csum <= '0;
            end else if (capture) begin
                csum <= csum ^ dout_mem;
            end
`endif
            case (state)
                ST_IDLE: state <= ST_SCAN;
                ST_SCAN: begin
                    if (req_rx && ack_rx) begin
                        req_rx   <= 1'b0;
                        cur_addr <= flag_rx ? last_addr : din_rx[ADDR_W-1:0];
                        line_cnt <= '0;
                        word_cnt <= '0;
                        pfx_idx  <= 1'b0;
                        state    <= ST_PFX;
                    end else begin
                        req_rx <= 1'b1;
                    end
                end
                ST_PFX: begin
                    if (tx_done) begin
                        pfx_idx <= 1'b1;
                        if (pfx_idx) begin
                            state <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: if (tx_done) state <= ST_COLON;
                ST_COLON, ST_SEP: begin
                    if (tx_done) begin
                        if (MEM_LAT == 0) begin
                            state <= ST_WORD;
                        end else begin
                            lat_cnt <= LAT_INIT;
                            state   <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (lat_cnt == 2'd0) begin
                        state <= ST_WORD;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                ST_WORD: begin
                    if (tx_done) begin
                        cur_addr <= cur_addr + STEP;
                        if (word_cnt == WPL_LAST) begin
                            word_cnt <= '0;
`ifdef DCP_DUMP_CSUM_EN
                            state    <= ST_CSUM_MARK;
`else
                            state    <= ST_CR;
`endif
                        end else begin
                            word_cnt <= word_cnt + 4'd1;
                            state    <= ST_SEP;
                        end
                    end
                end
`ifdef DCP_DUMP_CSUM_EN
                ST_CSUM_MARK: if (tx_done) state <= ST_CSUM;
                ST_CSUM:      if (tx_done) state <= ST_CR;
`endif
                ST_CR: if (tx_done) state <= ST_LF;
                ST_LF: begin
                    if (tx_done) begin
                        if (line_cnt == LINE_LAST) begin
                            last_addr <= cur_addr;
                            finish    <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            line_cnt <= line_cnt + 8'd1;
                            state    <= ST_ADDR;
                        end
                    end
                end
                ST_DONE: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dcp_dump.md
# dcp_dump

Parametrised memory-dump command processor for the serial debug unit. On its command selector it reads a start address (or resumes after the last dump), then streams formatted lines of hex memory words through the transmitter handshake, and finally returns a finish flag to the dispatcher. It serves both the instruction-memory and data-memory dump commands by instantiation with different command codes, widths and line geometry.

## Interface
- `CMD_CODE`, 8'h49: `sel_mode` value that enables this block; also the echoed prefix character.
- `ADDR_W`, 32: memory address width.
- `DATA_W`, 32: memory word width; at most 32.
- `WORDS_PER_LINE`, 4: words printed per line; range 1..16.
- `LINES`, 2: lines printed per command; range 1..256.
- `ADDR_STEP`, 1: address increment per word.
- `MEM_LAT`, 0: memory read latency in cycles; range 0..3.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: synchronous, active-low reset.
- `sel_mode` in 8: dispatcher command selector; the block is enabled (`we`) while `sel_mode == CMD_CODE`.
- `finish` out 1: command complete.
- `addr` out ADDR_W: memory read address.
- `dout_mem` in DATA_W: memory read data.
- `din_rx` in 32: parsed hex value from the receiver.
- `flag_rx` in 1: the receiver got an empty line, meaning resume.
- `ack_rx` in 1: receiver acknowledge.
- `req_rx` out 1: receiver request.
- `type_rx` out 1: constant 1, requesting a hex-word parse.
- `ack_tx` in 1: transmitter acknowledge.
- `req_tx` out 1: transmitter request.
- `type_tx` out 1: 0 sends the low 8 bits of `dout` as a character; 1 sends `dout` as an 8-digit hex word.
- `dout` out 32: transmit payload; memory words are zero-extended.

## Operation
- **States:** IDLE, SCAN, PFX, ADDR, COLON, RD, WORD, SEP, (CSUM_MARK, CSUM), CR, LF, DONE.
- **IDLE:** moves to SCAN when `we` is true.
- **SCAN:**
  - Holds `req_rx=1` until `ack_rx`.
  - On `ack_rx`, loads the current address from `din_rx[ADDR_W-1:0]`. If `flag_rx=1`, it loads `last_addr` instead.
  - Clears the line counter and word counter, then moves to PFX.
- **PFX:** emits two characters, `CMD_CODE` then 0x2D ('-'), once per command. It then goes to ADDR.
- **Per line:**
  - ADDR emits the current address as hex (type 1).
  - COLON emits 0x3A.
  - Then the word loop runs: RD → WORD → SEP.
- **Word loop:**
  - RD waits `MEM_LAT` cycles, then captures `dout_mem` into a data register. With `MEM_LAT=0`, capture happens in the same cycle RD is entered.
  - WORD emits the data register and then advances the address by `ADDR_STEP`.
  - SEP emits 0x20 between words only; the last word of a line has no trailing space.
- **End of line:**
  - CR emits 0x0D and LF emits 0x0A.
  - If further lines remain, the FSM returns to ADDR with the already-advanced address. Otherwise it goes to DONE.
- **DONE:**
  - Stores `last_addr` ← current address, i.e. the address after the last word printed.
  - Sets `finish=1` and holds it until `we` falls.
- **`we` falls in any state:** the FSM returns to IDLE on the next edge, clears `req_tx`, `req_rx` and `finish`, and leaves `last_addr` unchanged. A partial dump does not update `last_addr`.
- **Address arithmetic:** wraps modulo 2^ADDR_W. `addr` always equals the current address register.

## Timing
- **Reset values:** `finish=0`, `req_rx=0`, `req_tx=0`, `addr=0`, `last_addr=0`, state IDLE. `dout` and `type_tx` are combinational from the state: 0x20 and 0 in non-emitting states.
- **Transmit handshake:**
  - `req_tx` rises on the edge after an emitting state is entered.
  - `dout` and `type_tx` stay stable while `req_tx=1`.
  - On the edge where `ack_tx=1` is sampled, `req_tx` clears and the FSM advances in that same edge.
  - There is at least one cycle of `req_tx=0` between items.
- **Receive handshake:** same rule using `req_rx`/`ack_rx`.
- **`ack_tx` while `req_tx=0`:** ignored.
- **Cycle count:** with zero-wait acknowledge (`ack_tx` asserted one cycle after `req_tx`), each item costs 3 cycles and each word additionally costs `MEM_LAT` cycles in RD.
- **Re-entry:** from DONE, a new command requires `we` to fall and rise again.

## Configuration
- **`DCP_DUMP_CSUM_EN` defined:** after the last word of each line, the FSM emits 0x23 ('#') then a hex word equal to the XOR of that line's words, zero-extended to 32 bits, before CR. The accumulator clears at ADDR.
- **Undefined:** CSUM_MARK and CSUM states and the accumulator are absent; the line format is unchanged otherwise.

## Structure
- **Package `dcp_pkg`:** state enum; character constants (CHR_DASH 0x2D, CHR_COLON 0x3A, CHR_SP 0x20, CHR_CR 0x0D, CHR_LF 0x0A, CHR_HASH 0x23); `TX_CHAR`/`TX_HEX` type codes.
- **Sub-module `dcp_tx_port`:** owns the `req_tx`/`ack_tx` handshake. It takes `start`, payload and type, and returns a one-cycle `done`, so the FSM only sequences items.

## Test plan
- **Basic dump:** `CMD_CODE`=0x49, WPL=2, LINES=1, `din_rx`=0x10, mem[0x10]=0xAAAA0001, mem[0x11]=0xBBBB0002 → items 'I','-',0x10,':',0xAAAA0001,' ',0xBBBB0002,CR,LF; `finish=1`; `last_addr`=0x12.
- **Resume:** repeat the command with `flag_rx=1` → address item 0x12; `addr` steps 0x12, 0x13.
- **Wrap and latency:** `ADDR_W`=8, `din_rx`=0xFF, WPL=2, `MEM_LAT`=2 → words read from 0xFF then 0x00; each RD lasts 2 cycles.
- **Abort mid-dump:** drop `sel_mode` during the second WORD → IDLE next edge, `req_tx=0`, `finish=0`, `last_addr` unchanged. A following resume starts at the old `last_addr`.
- **Stalled acknowledge:** hold `ack_tx=0` for 10 cycles in COLON → `req_tx` stays 1, `dout`=0x3A stable, no state change.
- **Checksum:** with `DCP_DUMP_CSUM_EN` defined and line words 0x0F0F0000 and 0x00F0F00F → '#', then 0x0FFFF00F, before CR.
